// File: rtl/fifo_wr_frontend.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_wr_frontend
//
// Write-side front end of the async FIFO, in the wclk domain. It accepts a
// valid/ready word stream with frame delimiters into a 2-entry skid buffer
// (head/tail). It drives the FIFO write port from the head entry whenever the
// registered wfull from the write-pointer stage allows. It also keeps frame and
// back-pressure statistics for debug.
//
// Parameters
//   DSIZE     payload width in bits
//   DEPTH     FIFO address width; documents the pairing with the pointer stage
//
// Ports
//   wclk      write-domain clock, all state updates on the rising edge
//   wrst      synchronous active-high reset
//   en        accept enable; low blocks new words, buffered words still drain
//   s_valid   upstream word valid
//   s_data    upstream payload
//   s_last    final word of a frame
//   s_ready   buffer can take a word this cycle (registered state and wrst only)
//   wfull     FIFO full flag, registered in the write-pointer stage
//   winc      write strobe to the pointer stage and memory
//   wdata     {last, payload} of the head entry
//   in_frame  a frame has started and its last word is not yet accepted
//   frame_cnt frames fully written into the FIFO, wraps modulo 2^16
//   stall_cnt cycles with data pending while wfull is high, saturating
// -----------------------------------------------------------------------------
module fifo_wr_frontend #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic             en,
   input  logic             s_valid,
   input  logic [DSIZE-1:0] s_data,
   input  logic             s_last,
   output logic             s_ready,
   input  logic             wfull,
   output logic             winc,
   output logic [DSIZE:0]   wdata,
   output logic             in_frame,
   output logic [15:0]      frame_cnt,
   output logic [15:0]      stall_cnt
);

   // DEPTH drives no logic here; reject a meaningless value at elaboration.
   if (DEPTH < 1) begin : g_depth_check
      $error("fifo_wr_frontend: DEPTH must be at least 1");
   end

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_IN_FRAME = 1'b1
   } frame_state_e;

   logic [DSIZE:0] head_q, head_d;
   logic [DSIZE:0] tail_q, tail_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [15:0]    frame_cnt_q;
   logic [15:0]    stall_cnt_q;
   frame_state_e   state_q;

   logic           push;
   logic           pop;
   logic [DSIZE:0] s_word;

   assign s_word  = {s_last, s_data};

   // Ready depends only on occupancy and reset, so upstream never sees a
   // combinational path from s_valid or wfull. A pop from a full buffer frees
   // a slot only on the next cycle.
   assign s_ready = !wrst && (cnt_q != 2'd2);
   assign push    = s_valid && s_ready && en;
   assign pop     = (cnt_q != 2'd0) && !wfull;

   assign winc      = pop;
   assign wdata     = head_q;
   assign in_frame  = (state_q == ST_IN_FRAME);
   assign frame_cnt = frame_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // Skid buffer next state. The head is the only entry ever presented. The
   // tail is used only while a second word waits behind a blocked head.
   always_comb begin
      // NOTE: every signal gets a default before the case, so paths that leave
      // it untouched hold the register value instead of inferring a latch.
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
               head_d = s_word;
            end else begin
               tail_d = s_word;
            end
         end
         2'b01: begin
            cnt_d = cnt_q - 2'd1;
            // With one entry the head keeps its stale value, so wdata holds.
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
            end
         end
         2'b11: begin
            // Head leaves and the new word takes its place behind any tail word.
            if (cnt_q == 2'd1) begin
               head_d = s_word;
            end else begin
               head_d = tail_q;
               tail_d = s_word;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         // NOTE: the buffer entries are reset as well as the occupancy, because
         // wdata is a direct view of the head entry and must read 0 after reset.
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= 2'd0;
         frame_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         if (pop && head_q[DSIZE]) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if ((cnt_q != 2'd0) && wfull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   // Frame tracker: follows accepted words, not written ones.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q <= ST_IDLE;
      end else if (push) begin
         case (state_q)
            ST_IDLE:     state_q <= s_last ? ST_IDLE : ST_IN_FRAME;
            ST_IN_FRAME: state_q <= s_last ? ST_IDLE : ST_IN_FRAME;
            default:     state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_frontend.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_wr_frontend
//
// Directed bench for fifo_wr_frontend. Instance A carries all directed steps.
// Instance B runs 65 537 single-word frames alongside A's long stall phase, so
// the saturation and wrap checks share one pass of about 65.5k cycles.
// -----------------------------------------------------------------------------
module tb_fifo_wr_frontend;

   logic        wclk;
   logic        wrst, en, s_valid, s_last, wfull;
   logic [7:0]  s_data;
   logic        s_ready, winc, in_frame;
   logic [8:0]  wdata;
   logic [15:0] frame_cnt, stall_cnt;

   logic        b_wrst, b_en, b_s_valid, b_s_last, b_wfull;
   logic [7:0]  b_s_data;
   logic        b_s_ready, b_winc, b_in_frame;
   logic [8:0]  b_wdata;
   logic [15:0] b_frame_cnt, b_stall_cnt;

   int vectors;
   int miscompares;

   fifo_wr_frontend #(.DSIZE(8), .DEPTH(4)) u_dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .en        (en),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .in_frame  (in_frame),
      .frame_cnt (frame_cnt),
      .stall_cnt (stall_cnt)
   );

   fifo_wr_frontend #(.DSIZE(8), .DEPTH(4)) u_dut_b (
      .wclk      (wclk),
      .wrst      (b_wrst),
      .en        (b_en),
      .s_valid   (b_s_valid),
      .s_data    (b_s_data),
      .s_last    (b_s_last),
      .s_ready   (b_s_ready),
      .wfull     (b_wfull),
      .winc      (b_winc),
      .wdata     (b_wdata),
      .in_frame  (b_in_frame),
      .frame_cnt (b_frame_cnt),
      .stall_cnt (b_stall_cnt)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 ns after the rising edge; checks happen on the
   // falling edge, well away from the active edge.
   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic mid();
      @(negedge wclk);
   endtask

   // One cycle on instance A: drive, check handshake/write port, advance.
   task automatic drive_chk(input string tag, input logic v, input logic [7:0] d,
                            input logic l, input logic f, input logic e_ready,
                            input logic e_winc, input logic [8:0] e_wdata);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      wfull   = f;
      mid();
      check({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, e_ready});
      check({tag, ".winc"}, {31'd0, winc}, {31'd0, e_winc});
      if (e_winc) check({tag, ".wdata"}, {23'd0, wdata}, {23'd0, e_wdata});
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      wrst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; wfull = 1'b0;
      b_wrst = 1'b1; b_en = 1'b1; b_s_valid = 1'b0; b_s_data = 8'h00; b_s_last = 1'b0;
      b_wfull = 1'b0;

      // Reset held for two edges.
      tick();
      tick();
      mid();
      check("rst.s_ready",   {31'd0, s_ready},   32'd0);
      check("rst.winc",      {31'd0, winc},      32'd0);
      check("rst.wdata",     {23'd0, wdata},     32'd0);
      check("rst.in_frame",  {31'd0, in_frame},  32'd0);
      check("rst.frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      tick();
      wrst = 1'b0;

      // Stream 0x10..0x14, last on 0x14, no back-pressure.
      drive_chk("t1_w0", 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t1.in_frame_open", {31'd0, in_frame}, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         drive_chk("t1_w", 1'b1, 8'(8'h10 + k), (k == 4), 1'b0, 1'b1, 1'b1,
                   {1'b0, 8'(8'h10 + k - 1)});
      end
      check("t1.in_frame_closed", {31'd0, in_frame}, 32'd0);
      drive_chk("t1_tail", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h114);
      drive_chk("t1_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t1.frame_cnt", {16'd0, frame_cnt}, 32'd1);

      // Back-pressure: wfull high while three words are offered.
      drive_chk("t2_c0", 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
      check("t2.stall_1", {16'd0, stall_cnt}, 32'd0);
      drive_chk("t2_c1", 1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
      check("t2.stall_2", {16'd0, stall_cnt}, 32'd1);
      drive_chk("t2_c2", 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
      check("t2.stall_3", {16'd0, stall_cnt}, 32'd2);
      drive_chk("t2_c3", 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
      check("t2.stall_4", {16'd0, stall_cnt}, 32'd3);
      drive_chk("t2_c4", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 9'h020);
      drive_chk("t2_c5", 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 9'h021);
      drive_chk("t2_c6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h122);
      drive_chk("t2_c7", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t2.stall_final", {16'd0, stall_cnt}, 32'd3);
      check("t2.frame_cnt",   {16'd0, frame_cnt}, 32'd2);
      check("t2.in_frame",    {31'd0, in_frame},  32'd0);

      // Continuous stream with one stalled cycle: push/pop together at cnt=1.
      drive_chk("t3_c0", 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      drive_chk("t3_c1", 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 9'h040);
      drive_chk("t3_c2", 1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
      check("t3.head_held", {23'd0, wdata}, 32'h041);
      drive_chk("t3_c3", 1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b1, 9'h041);
      drive_chk("t3_c4", 1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 1'b1, 9'h042);
      drive_chk("t3_c5", 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 9'h043);
      drive_chk("t3_c6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h144);
      drive_chk("t3_c7", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t3.frame_cnt", {16'd0, frame_cnt}, 32'd3);
      check("t3.stall_cnt", {16'd0, stall_cnt}, 32'd4);

      // en low: offered word is not consumed and frame state does not move.
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_chk("t4_off", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
         check("t4.in_frame_idle", {31'd0, in_frame}, 32'd0);
      end
      en = 1'b1;
      drive_chk("t4_on",   1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      drive_chk("t4_out",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h033);
      check("t4.in_frame_open", {31'd0, in_frame}, 32'd1);
      drive_chk("t4_once", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive_chk("t4_off2", 1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
         check("t4.in_frame_held", {31'd0, in_frame}, 32'd1);
      end
      en = 1'b1;
      drive_chk("t4_on2",   1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t4.in_frame_closed", {31'd0, in_frame}, 32'd0);
      drive_chk("t4_out2",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h134);
      drive_chk("t4_once2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t4.frame_cnt", {16'd0, frame_cnt}, 32'd4);

      // Reset mid-frame with both entries full.
      drive_chk("t6_a", 1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
      drive_chk("t6_b", 1'b1, 8'h51, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000);
      s_valid = 1'b0;
      mid();
      check("t6.in_frame_pre", {31'd0, in_frame}, 32'd1);
      check("t6.full_ready",   {31'd0, s_ready},  32'd0);
      tick();
      wrst  = 1'b1;
      wfull = 1'b0;
      mid();
      check("t6.rst_ready", {31'd0, s_ready}, 32'd0);
      tick();
      wrst = 1'b0;
      check("t6.in_frame",  {31'd0, in_frame},  32'd0);
      check("t6.frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("t6.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("t6.wdata",     {23'd0, wdata},     32'd0);
      drive_chk("t6_first", 1'b1, 8'h60, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000);
      drive_chk("t6_head",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h160);
      drive_chk("t6_end",   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
      check("t6.frame_cnt_after", {16'd0, frame_cnt}, 32'd1);

      // Saturation on A (one word stuck behind wfull) and frame wrap on B
      // (65 537 single-word frames), run side by side.
      wrst = 1'b1;
      tick();
      wrst   = 1'b0;
      b_wrst = 1'b0;
      for (int i = 0; i < 65540; i++) begin
         s_valid   = (i == 0);
         s_data    = 8'h70;
         s_last    = 1'b1;
         wfull     = 1'b1;
         b_s_valid = (i < 65537);
         b_s_data  = 8'(i);
         b_s_last  = 1'b1;
         if (i == 65534) begin
            mid();
            check("t5.stall_near", {16'd0, stall_cnt},   32'hFFFD);
            check("t5.frames_near", {16'd0, b_frame_cnt}, 32'hFFFD);
         end
         tick();
      end
      s_valid   = 1'b0;
      b_s_valid = 1'b0;
      mid();
      check("t5.stall_sat",   {16'd0, stall_cnt},   32'hFFFF);
      check("t5.winc_blocked", {31'd0, winc},       32'd0);
      check("t5.frame_wrap",  {16'd0, b_frame_cnt}, 32'd1);
      check("t5.b_drained",   {31'd0, b_winc},      32'd0);
      check("t5.b_in_frame",  {31'd0, b_in_frame},  32'd0);
      tick();
      tick();
      tick();
      check("t5.stall_hold", {16'd0, stall_cnt}, 32'hFFFF);
      drive_chk("t5_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 9'h170);
      check("t5.frame_cnt_a", {16'd0, frame_cnt}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_frontend.md
# fifo_wr_frontend

Write-side front end for the async FIFO, in the `wclk` domain directly upstream of the write-pointer stage. It accepts a valid/ready word stream with frame delimiters and buffers it in a 2-entry skid buffer. It drives the FIFO write port (`winc`/`wdata`), honouring the registered `wfull` from the pointer stage. It also keeps frame and back-pressure statistics for debug.

## Interface
- DSIZE, 8, payload width in bits
- DEPTH, 4, FIFO address width; carried for consistency, no logic depends on it beyond port documentation
- wclk  input  1  write-domain clock; all state updates on rising edge
- wrst  input  1  reset, synchronous, active-high
- en  input  1  accept enable; when low, no new words accepted, buffered words still drain
- s_valid  input  1  upstream word valid
- s_data  input  DSIZE  upstream payload
- s_last  input  1  marks final word of a frame
- s_ready  output  1  buffer can accept a word this cycle
- wfull  input  1  FIFO full flag from the write-pointer stage (registered there)
- winc  output  1  write strobe to the write-pointer stage and memory
- wdata  output  DSIZE+1  {last, payload} of the head buffer entry
- in_frame  output  1  an accepted frame has started and its last word has not yet been accepted
- frame_cnt  output  16  count of frames fully written into the FIFO
- stall_cnt  output  16  saturating count of cycles with data pending while wfull is high

## Operation
- Storage: 2 entries of DSIZE+1 bits in a head/tail arrangement, plus a 2-bit occupancy `cnt` (0..2).
- Push: `push = s_valid && s_ready && en`. The word is stored as {s_last, s_data} at the tail.
- Pop: `winc = (cnt != 0) && !wfull`. `wdata` is always the head entry. When `cnt == 0`, `wdata` holds its last value; it is not checked.
- Occupancy updates:
  - push only: cnt+1
  - pop only: cnt−1
  - push and pop together: cnt unchanged, and ordering is preserved (head advances, new word goes to the tail)
- `s_ready = !wrst && (cnt != 2)`. It is a function of registered state only, with no combinational path from `s_valid` or `wfull`. `en` does not gate `s_ready`. When `en` is low, handshakes are simply ignored: a word presented with `s_valid=1` while `s_ready=1` and `en=0` is NOT consumed.
- `in_frame` has two states:
  - IDLE: a push with `s_last=0` moves to IN_FRAME; a push with `s_last=1` stays in IDLE (single-word frame).
  - IN_FRAME: a push with `s_last=1` moves to IDLE; anything else stays in IN_FRAME.
- `frame_cnt` increments by 1 on each cycle with `winc && wdata[DSIZE]`. It wraps modulo 2^16.
- `stall_cnt` increments on each cycle with `(cnt != 0) && wfull`. It saturates at 16'hFFFF.
- The block never asserts `winc` while `wfull` is high.

## Timing
- Reset (`wrst` high at a rising edge) sets:
  - cnt=0, so `winc`=0
  - `s_ready`=0 while `wrst` is high
  - `in_frame`=0, `frame_cnt`=0, `stall_cnt`=0
  - `wdata`=0
- Reset mid-frame discards buffered words and frame state. No partial-frame recovery.
- `s_ready` goes to 1 in the first cycle after `wrst` falls.
- Latency: a word pushed at edge N is at the head with `winc`=1 in cycle N+1 if `wfull`=0. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained while `wfull`=0.
- `wfull` rising in the same cycle as a pending word blocks `winc` that cycle. The word stays at the head.
- With cnt=2 and a pop, `s_ready` is still 0 that cycle. It becomes 1 the next cycle. No push is lost or duplicated.

## Test plan
- Reset then stream: hold `wrst`=1 for 2 cycles, then send 5 words 0x10..0x14 with `s_last` on 0x14, `wfull`=0. Required: `winc` high for 5 consecutive cycles starting 1 cycle after the first push, `wdata` = {0,0x10}..{1,0x14}, `frame_cnt`=1, `in_frame` 1→0.
- Back-pressure: hold `wfull`=1 while sending 3 words. Required:
  - `s_ready` drops after 2 pushes; only 0x20 and 0x21 are buffered.
  - `winc`=0 throughout, and `stall_cnt` increments every cycle cnt≠0.
  - On releasing `wfull`, the order 0x20, 0x21, 0x22 is preserved with no loss.
- Simultaneous push/pop at cnt=1: a continuous stream with one stalled cycle. Required: cnt stays 1, data order intact, no duplicates.
- `en`=0: `s_valid`=1 with 0x33 for 3 cycles with `en`=0, then `en`=1. Required: exactly one 0x33 written; `in_frame` unchanged while `en`=0.
- Saturation/wrap: force 65 540 stall cycles. Required: `stall_cnt`=0xFFFF and holds. Write 65 537 single-word frames. Required: `frame_cnt`=1.
- Reset mid-frame: assert `wrst` with cnt=2 and `in_frame`=1. Required: next cycle `winc`=0, `in_frame`=0, counters 0, and the first word after reset appears as the head.
